sha256_pad_sequencer: RTL and testbench

Streaming SHA-256 message padder and block sequencer. It sits between the message source and the SHA-256 compression core. It takes a bit length and a stream of 32-bit message words, and emits complete 512-bit blocks as 16-word bursts with the `1` bit, zero fill and 64-bit length field inserted. It computes the block count itself and reports progress to the top-level miner control.

---
 rtl/sha256_pkg.sv | 26 ++
 rtl/sha256_word_mask.sv | 20 ++
 rtl/sha256_pad_sequencer.sv | 131 +++++++++++++
 tb/tb_sha256_pad_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and block-count helper for the SHA-256 padder.
package sha256_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned LEN_FIELD_W = 64;
    localparam int unsigned BLOCK_BITS  = WORD_W * BLOCK_WORDS;

    typedef enum logic [1:0] {
        IDLE,
        MSG,
        PAD
    } pad_state_t;

    // Smallest block count that holds message + the '1' bit + the 64-bit length field.
    function automatic logic [1:0] calc_num_blocks(input logic [31:0] len);
        if (len <= BLOCK_BITS - LEN_FIELD_W - 1) begin
            return 2'd1;
        end else if (len <= 2 * BLOCK_BITS - LEN_FIELD_W - 1) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

endpackage

// File: rtl/sha256_word_mask.sv
// Builds the boundary word: keeps the top r message bits, appends the '1' bit, clears the rest.
module sha256_word_mask
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] data,
    input  logic [4:0]        r,
    output logic [WORD_W-1:0] word
);

    logic [WORD_W-1:0] keep;
    logic [WORD_W-1:0] one_bit;

    // With r = 0 this yields 0x80000000 regardless of data.
    always_comb begin
        keep    = ~({WORD_W{1'b1}} >> r);
        one_bit = {1'b1, {(WORD_W - 1){1'b0}}} >> r;
        word    = (data & keep) | one_bit;
    end

endmodule

// File: rtl/sha256_pad_sequencer.sv
// Streaming SHA-256 padder: forwards message words, inserts the '1' bit, zero fill
// and length field, and frames the result as 16-word blocks.
module sha256_pad_sequencer
    import sha256_pkg::*;
#(
    parameter int unsigned LEN_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_first,
    output logic              out_blk_last,
    output logic              out_msg_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        num_blocks
);

    pad_state_t        state_q, state_d;
    logic [5:0]        g_q, g_d;
    logic [1:0]        n_q, n_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              done_q, done_d;

    logic [5:0]        q_words;
    logic [4:0]        r_bits;
    logic [5:0]        last_in;
    logic [5:0]        last_g;
    logic [31:0]       msg_len_ext;
    logic [WORD_W-1:0] masked;

    assign q_words     = 6'(len_q >> 5);
    assign r_bits      = len_q[4:0];
    // Index of the last word taken from the input stream.
    assign last_in     = (r_bits != 5'd0) ? q_words : q_words - 6'd1;
    assign last_g      = {n_q - 2'd1, 4'hF};
    assign msg_len_ext = 32'(msg_len);

    sha256_word_mask u_word_mask (
        .data (in_data),
        .r    (r_bits),
        .word (masked)
    );

    // Next-state, counter and datapath muxing.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        n_d       = n_q;
        len_d     = len_q;
        done_d    = 1'b0;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        out_data  = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = msg_len;
                    n_d     = calc_num_blocks(msg_len_ext);
                    g_d     = 6'd0;
                    state_d = (msg_len != '0) ? MSG : PAD;
                end
            end
            MSG: begin
                out_valid = in_valid;
                in_ready  = out_ready;
                out_data  = (g_q == q_words) ? masked : in_data;
                if (in_valid && out_ready) begin
                    g_d = g_q + 6'd1;
                    if (g_q == last_in) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                out_valid = 1'b1;
                // g = Q only reaches PAD when the message ended on a word boundary.
                if (g_q == q_words && r_bits == 5'd0) begin
                    out_data = {1'b1, {(WORD_W - 1){1'b0}}};
                end else if (g_q == last_g) begin
                    out_data = WORD_W'(len_q);
                end
                if (out_ready) begin
                    if (g_q == last_g) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        g_d     = 6'd0;
                    end else begin
                        g_d = g_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Framing flags are masked in IDLE so they read 0 between messages.
    always_comb begin
        busy         = (state_q != IDLE);
        out_first    = busy && (g_q[3:0] == 4'd0);
        out_blk_last = busy && (g_q[3:0] == 4'd15);
        out_msg_last = out_blk_last && (g_q[5:4] == n_q - 2'd1);
        done         = done_q;
        num_blocks   = n_q;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= 6'd0;
            n_q     <= 2'd0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            n_q     <= n_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_sha256_pad_sequencer.sv
// Self-checking bench for sha256_pad_sequencer: table vectors, random streams with
// stalls against a bit-level padding model, and reset/busy-start sequences.
module tb_sha256_pad_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  msg_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_first;
    logic        out_blk_last;
    logic        out_msg_last;
    logic        busy;
    logic        done;
    logic [1:0]  num_blocks;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] msg_words [32];
    logic [31:0] got [48];

    typedef struct {
        int          len;
        logic [31:0] fill;
        int          idx;
        logic [31:0] val;
        int          n;
    } vec_t;

    vec_t vecs [10];

    sha256_pad_sequencer #(.LEN_W(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .msg_len      (msg_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_first    (out_first),
        .out_blk_last (out_blk_last),
        .out_msg_last (out_msg_last),
        .busy         (busy),
        .done         (done),
        .num_blocks   (num_blocks)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Smallest N such that message, the '1' bit and the 64-bit length fit in N*512 bits.
    function automatic int model_n(input int len);
        int n = 1;
        while (len + 65 > 512 * n) n++;
        return n;
    endfunction

    // Padded message viewed as a bit string: message bits, a '1', zeros, 64-bit length.
    function automatic logic [31:0] ref_word(input int len, input int n, input int idx);
        logic [31:0] w = '0;
        for (int b = 0; b < 32; b++) begin
            int p = idx * 32 + b;
            if (p < len) w[31-b] = msg_words[p/32][31-(p%32)];
            else if (p == len) w[31-b] = 1'b1;
        end
        if (idx == 16 * n - 1) w = 32'(len);
        else if (idx == 16 * n - 2) w = '0;
        return w;
    endfunction

    // Runs one message; start is raised in the current cycle (may coincide with done).
    task automatic run_msg(input int len, input bit rnd, input int busy_start_at);
        int n, nin, in_idx, cnt, cyc, viol;
        bit done_seen, stall_prev, hold_in;
        logic [35:0] held;
        n = model_n(len);
        nin = (len + 31) / 32;
        start = 1'b1;
        msg_len = 10'(len);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_after_start", 64'(busy), 64'd1);
        in_idx = 0; cnt = 0; cyc = 0; viol = 0;
        done_seen = 0; stall_prev = 0; hold_in = 0; held = '0;
        while (!done_seen && cyc < 3000) begin
            if (cyc == busy_start_at) begin
                start = 1'b1;
                msg_len = 10'd900;
            end else begin
                start = 1'b0;
            end
            if (!hold_in) in_valid = (in_idx < nin) && (!rnd || ($urandom_range(3) != 0));
            in_data = in_valid ? msg_words[in_idx] : $urandom;
            out_ready = !rnd || ($urandom_range(2) != 0);
            #1;
            if (stall_prev)
                chk("stall_hold", 64'({out_valid, out_first, out_blk_last, out_msg_last, out_data}),
                    64'(held));
            stall_prev = out_valid && !out_ready;
            held = {out_valid, out_first, out_blk_last, out_msg_last, out_data};
            hold_in = in_valid && !in_ready;
            if (in_ready && in_idx >= nin) viol++;
            if (out_valid && out_ready) begin
                if (cnt < 48) got[cnt] = out_data;
                chk($sformatf("flags_w%0d", cnt),
                    64'({out_first, out_blk_last, out_msg_last}),
                    64'({cnt % 16 == 0, cnt % 16 == 15, cnt == 16 * n - 1}));
                cnt++;
            end
            if (in_valid && in_ready) in_idx++;
            @(negedge clk);
            cyc++;
            if (done) done_seen = 1;
        end
        start = 1'b0;
        in_valid = 1'b0;
        chk("done_seen", 64'(done_seen), 64'd1);
        chk("word_count", 64'(cnt), 64'(16 * n));
        chk("in_consumed", 64'(in_idx), 64'(nin));
        chk("in_ready_beyond_msg", 64'(viol), 64'd0);
        chk("num_blocks_model", 64'(num_blocks), 64'(n));
        if (!rnd) chk("duration", 64'(cyc), 64'(16 * n));
        for (int i = 0; i < cnt && i < 16 * n; i++)
            chk($sformatf("len%0d_w%0d", len, i), 64'(got[i]), 64'(ref_word(len, n, i)));
    endtask

    initial begin
        int dcount;
        int rlen;
        vecs[0] = '{len: 0,   fill: 32'h0,        idx: 0,  val: 32'h80000000, n: 1};
        vecs[1] = '{len: 24,  fill: 32'h616263FF, idx: 0,  val: 32'h61626380, n: 1};
        vecs[2] = '{len: 24,  fill: 32'h616263FF, idx: 15, val: 32'h00000018, n: 1};
        vecs[3] = '{len: 447, fill: 32'hFFFFFFFF, idx: 13, val: 32'hFFFFFFFF, n: 1};
        vecs[4] = '{len: 447, fill: 32'hFFFFFFFF, idx: 14, val: 32'h00000000, n: 1};
        vecs[5] = '{len: 447, fill: 32'hFFFFFFFF, idx: 15, val: 32'h000001BF, n: 1};
        vecs[6] = '{len: 448, fill: 32'hFFFFFFFF, idx: 14, val: 32'h80000000, n: 2};
        vecs[7] = '{len: 448, fill: 32'hFFFFFFFF, idx: 31, val: 32'h000001C0, n: 2};
        vecs[8] = '{len: 959, fill: 32'hA5A5A5A5, idx: 31, val: 32'h000003BF, n: 2};
        vecs[9] = '{len: 960, fill: 32'h5A5A5A5A, idx: 47, val: 32'h000003C0, n: 3};

        rst_n = 1'b0; start = 1'b0; msg_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_values",
            64'({busy, done, out_valid, in_ready, out_first, out_blk_last, out_msg_last,
                 num_blocks, out_data}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, run back to back so each start lands in the previous done cycle.
        foreach (vecs[k]) begin
            for (int i = 0; i < 32; i++) msg_words[i] = vecs[k].fill;
            run_msg(vecs[k].len, 1'b0, -1);
            chk($sformatf("vec%0d_word%0d", k, vecs[k].idx), 64'(got[vecs[k].idx]),
                64'(vecs[k].val));
            chk($sformatf("vec%0d_num_blocks", k), 64'(num_blocks), 64'(vecs[k].n));
        end

        // Maximum-length message with random stalls on both sides.
        for (int i = 0; i < 32; i++) msg_words[i] = $urandom;
        run_msg(1023, 1'b1, -1);
        chk("max_num_blocks", 64'(num_blocks), 64'd3);
        chk("max_word31", 64'(got[31]), 64'({msg_words[31][31:1], 1'b1}));
        chk("max_word47", 64'(got[47]), 64'h3FF);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) msg_words[i] = $urandom;
            rlen = int'($urandom_range(1023));
            run_msg(rlen, 1'b1, -1);
        end

        // Reset in the middle of a message at g = 5.
        for (int i = 0; i < 32; i++) msg_words[i] = $urandom;
        start = 1'b1;
        msg_len = 10'd448;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = msg_words[i];
            out_ready = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_midmsg",
            64'({busy, done, out_valid, in_ready, out_first, out_blk_last, out_msg_last,
                 num_blocks, out_data}), 64'd0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("no_done_after_reset", 64'(dcount), 64'd0);

        // Start while busy must be ignored, msg_len must not be re-sampled.
        for (int i = 0; i < 32; i++) msg_words[i] = $urandom;
        run_msg(100, 1'b0, 3);
        chk("busy_start_num_blocks", 64'(num_blocks), 64'd1);
        chk("busy_start_len_word", 64'(got[15]), 64'd100);

        run_msg(0, 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
